// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I width codes, load/store sequencer states and byte-enable constants
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/ld_converter.sv
// rtl/ld_converter.sv - sign/zero extension of a lane-aligned load word by RV32I width code
module ld_converter
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    output logic [31:0] data
);

    always_comb begin
        data = word;
        case (funct3)
            F3_B:    data = {{24{word[7]}}, word[7:0]};
            F3_BU:   data = {24'h0, word[7:0]};
            F3_H:    data = {{16{word[15]}}, word[15:0]};
            F3_HU:   data = {16'h0, word[15:0]};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store sequencer for a req/gnt/rvalid data memory
module lsu_ctrl
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // Fault covers both misalignment and width codes that are illegal for the direction.
    function automatic logic access_fault(input logic st, input logic [2:0] f3, input logic [1:0] off);
        logic f;
        case (f3)
            F3_B:    f = 1'b0;
            F3_H:    f = off[0];
            F3_W:    f = (off != 2'b00);
            F3_BU:   f = st;
            F3_HU:   f = st | off[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = BE_BYTE << off;
            2'b01:   be = BE_HALF << off;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    lsu_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_store_q, mis_q, err_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q, wdata_q, word_q, ld_data;
    logic [3:0]  be_q;
    logic        accept, timeout, capture;

    ld_converter u_ld_converter (
        .funct3 (funct3_q),
        .word   (word_q),
        .data   (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        timeout    = 1'b0;
        capture    = 1'b0;
        req_ready  = (state_q == LSU_IDLE);
        busy       = (state_q != LSU_IDLE);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_be     = 4'h0;
        mem_wdata  = 32'h0;
        resp_valid = 1'b0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        rdata      = 32'h0;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = access_fault(is_store, funct3, addr[1:0]) ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                mem_req   = 1'b1;
                mem_we    = is_store_q;
                mem_addr  = addr_q;
                mem_be    = be_q;
                mem_wdata = wdata_q;
                if (mem_gnt) begin
                    cnt_d   = 8'd0;
                    state_d = is_store_q ? LSU_DONE : LSU_WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = LSU_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LSU_WAIT: begin
                if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = LSU_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = LSU_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                resp_valid = 1'b1;
                misaligned = mis_q;
                bus_err    = err_q;
                rdata      = (is_store_q | mis_q | err_q) ? 32'h0 : ld_data;
                state_d    = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            word_q     <= 32'h0;
            mis_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                is_store_q <= is_store;
                funct3_q   <= funct3;
                off_q      <= addr[1:0];
                addr_q     <= {addr[31:2], 2'b00};
                be_q       <= lane_be(funct3, addr[1:0]);
                wdata_q    <= lane_wdata(funct3, wdata);
                word_q     <= 32'h0;
                mis_q      <= access_fault(is_store, funct3, addr[1:0]);
                err_q      <= 1'b0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
            if (capture) begin
                word_q <= mem_rdata >> {off_q, 3'b000};
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a byte-level reference memory
module tb_lsu_ctrl;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        int          kind;
        int          accept_edge;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          mode;
        int          gdly;
        int          rdly;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        req_ready, resp_valid, misaligned, bus_err, busy;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int cyc = 0;
    int n_cmp = 0, n_bad = 0;
    int last_gnt_edge = 0, last_rv_edge = 0;
    resp_t exp_resp[$];
    bus_t  exp_bus[$];
    logic [7:0]  ref_bytes [0:1023];
    logic [31:0] mem_arr [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: byte-addressed memory, sizes and extension from the ISA rules.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input int mode,
                                  output resp_t r, output bit hb, output bus_t b);
        int size, off, base;
        logic [31:0] v;
        bit legal;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off   = int'(a[1:0]);
        base  = int'(a[9:0]);
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
        r = '{rdata: 32'h0, mis: 1'b0, err: 1'b0, kind: 0, accept_edge: 0};
        b = '{addr: 32'h0, we: 1'b0, be: 4'h0, wdata: 32'h0, mode: mode, gdly: 0, rdly: 0};
        hb = 1'b0;
        if (!legal || (off % size) != 0) begin
            r.mis = 1'b1;
            return;
        end
        hb     = 1'b1;
        b.addr = a & 32'hFFFF_FFFC;
        b.we   = st;
        for (int i = 0; i < size; i++) b.be[off + i] = 1'b1;
        for (int j = 0; j < 4; j++) b.wdata[8*j +: 8] = wd[8*(j % size) +: 8];
        if (mode == 1 || mode == 2) begin
            r.err  = 1'b1;
            r.kind = 3;
        end else if (st) begin
            for (int i = 0; i < size; i++) ref_bytes[base + i] = wd[8*i +: 8];
            r.kind = 1;
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_bytes[base + i];
            if (!f3[2] && size < 4 && v[8*size-1])
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            r.rdata = v;
            r.kind  = 2;
        end
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        mem_arr[a[9:2]] = w;
        for (int i = 0; i < 4; i++) ref_bytes[int'({a[9:2], 2'b00}) + i] = w[8*i +: 8];
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int mode, input int gdly,
                         input int rdly, input bit push_resp);
        resp_t r;
        bus_t  b;
        bit    hb;
        int    k;
        model(st, f3, a, wd, mode, r, hb, b);
        b.gdly = gdly;
        b.rdly = rdly;
        @(negedge clk);
        is_store = st; funct3 = f3; addr = a; wdata = wd; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1");
            req_valid = 1'b0;
            return;
        end
        r.accept_edge = cyc + 1;
        if (hb) exp_bus.push_back(b);
        if (push_resp) exp_resp.push_back(r);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        addr = $urandom;
        wdata = $urandom;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_resp.size() != 0 || !req_ready) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", 32'(exp_resp.size()), 32'd0);
    endtask

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                if (exp_resp.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
                end else begin
                    e = exp_resp.pop_front();
                    check("rdata", rdata, e.rdata);
                    check("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
                    check("bus_err", {31'b0, bus_err}, {31'b0, e.err});
                    case (e.kind)
                        0: check("lat_misaligned", 32'(cyc), 32'(e.accept_edge));
                        1: check("lat_store", 32'(cyc), 32'(last_gnt_edge));
                        2: check("lat_load", 32'(cyc), 32'(last_rv_edge));
                        default: ;
                    endcase
                end
            end
        end
    end

    // Memory model: checks each request against the expected bus transaction.
    initial begin
        bus_t b;
        int k, rd;
        logic [31:0] da, dw;
        logic [3:0] dbe;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        forever begin
            if (!(rst_n && mem_req)) begin
                @(negedge clk);
                continue;
            end
            if (exp_bus.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_mem_req: got mem_req=1 expected 0");
                k = 0;
                while (mem_req && k < 50) begin @(negedge clk); k++; end
                continue;
            end
            b = exp_bus.pop_front();
            da = mem_addr; dbe = mem_be; dw = mem_wdata;
            check("mem_addr", da, b.addr);
            check("mem_we", {31'b0, mem_we}, {31'b0, b.we});
            check("mem_be", {28'b0, dbe}, {28'b0, b.be});
            check("mem_wdata", dw, b.wdata);
            if (b.mode == 1) begin
                k = 0;
                while (mem_req && k < 50) begin @(negedge clk); k++; end
                check("req_cycles_to_timeout", 32'(k), 32'(TO));
                continue;
            end
            repeat (b.gdly) begin
                @(negedge clk);
                check("req_held", {31'b0, mem_req}, 32'd1);
            end
            mem_gnt = 1'b1;
            last_gnt_edge = cyc + 1;
            @(negedge clk);
            mem_gnt = 1'b0;
            check("req_drop_after_gnt", {31'b0, mem_req}, 32'd0);
            if (b.we) begin
                for (int j = 0; j < 4; j++)
                    if (dbe[j]) mem_arr[da[9:2]][8*j +: 8] = dw[8*j +: 8];
            end else if (b.mode != 3) begin
                rd = (b.mode == 2) ? TO + 1 : b.rdly;
                repeat (rd) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata = mem_arr[da[9:2]];
                last_rv_edge = cyc + 1;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: got no completion expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic st;
        logic [2:0] f3;
        logic [31:0] a;
        int mode;
        for (int w = 0; w < 256; w++) preload(32'(w * 4), $urandom);
        repeat (3) @(negedge clk);
        check("rst_ctrl", {25'b0, req_ready, busy, resp_valid, mem_req, mem_we, misaligned, bus_err},
              32'h40);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, {28'h0, mem_be});
        rst_n = 1'b1;

        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1'b1);
        issue(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 1, 0, 1'b1);
        wait_idle();
        preload(32'h200, 32'h12F0_3456);
        issue(1'b0, 3'b000, 32'h202, 32'h0, 0, 0, 2, 1'b1);
        issue(1'b0, 3'b100, 32'h202, 32'h0, 0, 3, 3, 1'b1);
        wait_idle();
        preload(32'h200, 32'h8001_7777);
        issue(1'b0, 3'b001, 32'h202, 32'h0, 0, 0, 0, 1'b1);
        issue(1'b0, 3'b010, 32'h201, 32'h0, 0, 0, 0, 1'b1);
        issue(1'b1, 3'b100, 32'h204, 32'h0, 0, 0, 0, 1'b1);
        issue(1'b0, 3'b010, 32'h208, 32'h0, 1, 0, 0, 1'b1);
        issue(1'b0, 3'b101, 32'h20A, 32'h0, 2, 0, 0, 1'b1);
        issue(1'b0, 3'b010, 32'h20C, 32'h0, 0, 0, 0, 1'b1);
        wait_idle();

        issue(1'b0, 3'b010, 32'h100, 32'h0, 3, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("busy_before_rst", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {25'b0, req_ready, busy, resp_valid, mem_req, mem_we, misaligned, bus_err},
              32'h40);
        check("midrst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 1, 1'b1);
        wait_idle();

        for (int t = 0; t < 150; t++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) < 7) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1]) a[1:0] = 2'b00;
            end
            mode = ($urandom_range(0, 19) == 0) ? 1 : 0;
            if (!st && $urandom_range(0, 19) == 0) mode = 2;
            issue(st, f3, a, $urandom, mode, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end
        wait_idle();
        repeat (TO + 4) @(negedge clk);
        check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
